// File: rtl/conv_operand_loader.sv
// Byte-stream front end for the single-PE 3x3 convolution engine: deserializes 25 operand
// bytes, runs the engine for a fixed window, then holds the result until acknowledged.
module conv_operand_loader #(
    parameter int ENGINE_CYCLES = 64
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       ack,
    output logic [7:0] i00, output logic [7:0] i01, output logic [7:0] i02, output logic [7:0] i03,
    output logic [7:0] i10, output logic [7:0] i11, output logic [7:0] i12, output logic [7:0] i13,
    output logic [7:0] i20, output logic [7:0] i21, output logic [7:0] i22, output logic [7:0] i23,
    output logic [7:0] i30, output logic [7:0] i31, output logic [7:0] i32, output logic [7:0] i33,
    output logic [7:0] f00, output logic [7:0] f01, output logic [7:0] f02,
    output logic [7:0] f10, output logic [7:0] f11, output logic [7:0] f12,
    output logic [7:0] f20, output logic [7:0] f21, output logic [7:0] f22,
    output logic       eng_rst,
    output logic       busy,
    output logic       done,
    output logic [4:0] load_idx
);

    localparam logic [7:0] RUN_LAST = 8'(ENGINE_CYCLES - 1);
    localparam logic [4:0] LAST_IDX = 5'd24;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    state_t     state, state_nxt;
    logic       beat;
    logic [7:0] run_cnt;
    logic [7:0] ops [25];

    assign beat = in_valid && (state == S_LOAD);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (beat && load_idx == LAST_IDX) state_nxt = S_RUN;
            S_RUN:   if (run_cnt == RUN_LAST)          state_nxt = S_DONE;
            S_DONE:  if (ack)                          state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Write pointer and run-window counter; the counter restarts whenever a load is in progress.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            load_idx <= '0;
            run_cnt  <= '0;
        end else begin
            if (beat) load_idx <= (load_idx == LAST_IDX) ? 5'd0 : load_idx + 5'd1;
            if (state == S_RUN) run_cnt <= run_cnt + 8'd1;
            else                run_cnt <= '0;
        end
    end

    // Operands only move on a beat that addresses them, so old values survive DONE->LOAD.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 25; k++) ops[k] <= '0;
        end else if (beat) begin
            ops[load_idx] <= in_data;
        end
    end

    assign in_ready = (state == S_LOAD);
    assign eng_rst  = (state == S_LOAD);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    assign i00 = ops[0];  assign i01 = ops[1];  assign i02 = ops[2];  assign i03 = ops[3];
    assign i10 = ops[4];  assign i11 = ops[5];  assign i12 = ops[6];  assign i13 = ops[7];
    assign i20 = ops[8];  assign i21 = ops[9];  assign i22 = ops[10]; assign i23 = ops[11];
    assign i30 = ops[12]; assign i31 = ops[13]; assign i32 = ops[14]; assign i33 = ops[15];
    assign f00 = ops[16]; assign f01 = ops[17]; assign f02 = ops[18];
    assign f10 = ops[19]; assign f11 = ops[20]; assign f12 = ops[21];
    assign f20 = ops[22]; assign f21 = ops[23]; assign f22 = ops[24];

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader: a job-level reference model checked every cycle,
// plus literal spot checks, and a second instance with a one-cycle run window.
module tb_conv_operand_loader;

    localparam int EC = 64;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_valid1 = 1'b0;
    logic [7:0] in_data = '0, in_data1 = '0;
    logic       ack = 1'b0, ack1 = 1'b0;
    logic       in_ready, eng_rst, busy, done;
    logic       in_ready1, eng_rst1, busy1, done1;
    logic [4:0] load_idx, load_idx1;
    logic [7:0] o  [25];
    logic [7:0] o1 [25];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    conv_operand_loader #(.ENGINE_CYCLES(EC)) dut (
        .clk_in(clk_in), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ack(ack),
        .i00(o[0]),  .i01(o[1]),  .i02(o[2]),  .i03(o[3]),
        .i10(o[4]),  .i11(o[5]),  .i12(o[6]),  .i13(o[7]),
        .i20(o[8]),  .i21(o[9]),  .i22(o[10]), .i23(o[11]),
        .i30(o[12]), .i31(o[13]), .i32(o[14]), .i33(o[15]),
        .f00(o[16]), .f01(o[17]), .f02(o[18]),
        .f10(o[19]), .f11(o[20]), .f12(o[21]),
        .f20(o[22]), .f21(o[23]), .f22(o[24]),
        .eng_rst(eng_rst), .busy(busy), .done(done), .load_idx(load_idx)
    );

    conv_operand_loader #(.ENGINE_CYCLES(1)) dut1 (
        .clk_in(clk_in), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .ack(ack1),
        .i00(o1[0]),  .i01(o1[1]),  .i02(o1[2]),  .i03(o1[3]),
        .i10(o1[4]),  .i11(o1[5]),  .i12(o1[6]),  .i13(o1[7]),
        .i20(o1[8]),  .i21(o1[9]),  .i22(o1[10]), .i23(o1[11]),
        .i30(o1[12]), .i31(o1[13]), .i32(o1[14]), .i33(o1[15]),
        .f00(o1[16]), .f01(o1[17]), .f02(o1[18]),
        .f10(o1[19]), .f11(o1[20]), .f12(o1[21]),
        .f20(o1[22]), .f21(o1[23]), .f22(o1[24]),
        .eng_rst(eng_rst1), .busy(busy1), .done(done1), .load_idx(load_idx1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level model: loading phase, engine cycles left, waiting for ack.
    int       m_ops [25];
    int       m_idx;
    bit       m_loading;
    int       m_run_left;
    bit       m_done;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 25; k++) m_ops[k] = 0;
            m_idx = 0; m_loading = 1; m_run_left = 0; m_done = 0;
        end else if (m_loading) begin
            if (in_valid) begin
                m_ops[m_idx] = int'(in_data);
                if (m_idx == 24) begin
                    m_idx = 0; m_loading = 0; m_run_left = EC;
                end else begin
                    m_idx++;
                end
            end
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) m_done = 1;
        end else if (m_done && ack) begin
            m_done = 0; m_loading = 1;
        end
    end

    always @(negedge clk_in) begin
        check("in_ready", int'(in_ready), int'(m_loading));
        check("eng_rst",  int'(eng_rst),  int'(m_loading));
        check("busy",     int'(busy),     int'(m_run_left > 0));
        check("done",     int'(done),     int'(m_done));
        check("load_idx", int'(load_idx), m_idx);
        for (int k = 0; k < 25; k++) check($sformatf("op%0d", k), int'(o[k]), m_ops[k]);
    end

    task automatic stream(input int base, input bit bubbles);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_in);
            if (bubbles) begin
                in_valid = 1'b0;
                @(negedge clk_in);
            end
            in_valid = 1'b1;
            in_data  = 8'(base + i);
        end
        @(negedge clk_in);
        in_valid = 1'b0;
    endtask

    // Returns the number of cycles seen with busy=1 and eng_rst=0 before done.
    task automatic wait_done(output int run_cycles);
        run_cycles = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (busy && !eng_rst) run_cycles++;
            @(negedge clk_in);
        end
        check("done_reached", int'(done), 1);
    endtask

    task automatic pulse_ack();
        @(negedge clk_in);
        ack = 1'b1;
        @(negedge clk_in);
        ack = 1'b0;
    endtask

    int runc;

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_eng_rst", int'(eng_rst), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_load_idx", int'(load_idx), 0);
        check("rst_i00", int'(o[0]), 0);
        rst = 1'b0;

        // Job 1: back-to-back stream 1..25
        stream(1, 1'b0);
        check("ready_drop", int'(in_ready), 0);
        check("lit_i00", int'(o[0]), 1);
        check("lit_i03", int'(o[3]), 4);
        check("lit_i33", int'(o[15]), 16);
        check("lit_f00", int'(o[16]), 17);
        check("lit_f22", int'(o[24]), 25);
        wait_done(runc);
        check("run_window", runc, 64);

        // Linger in DONE with traffic offered on the input
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (10) @(negedge clk_in);
        check("done_hold", int'(done), 1);
        check("done_no_eng", int'(eng_rst), 0);
        in_valid = 1'b0;
        pulse_ack();
        check("ack_ready", int'(in_ready), 1);
        check("ack_eng_rst", int'(eng_rst), 1);
        check("ack_idx", int'(load_idx), 0);
        check("hold_i00", int'(o[0]), 1);
        check("hold_f22", int'(o[24]), 25);

        // Job 2: bubbled stream; ack raised during RUN and held into DONE
        stream(1, 1'b1);
        check("bub_i33", int'(o[15]), 16);
        repeat (10) @(negedge clk_in);
        ack = 1'b1;
        wait_done(runc);
        check("run_window_bub", runc, 54);
        @(negedge clk_in);
        ack = 1'b0;
        check("ack_held_done", int'(done), 0);
        check("ack_held_ready", int'(in_ready), 1);

        // Reset mid-transfer
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            in_valid = 1'b1; in_data = 8'(50 + i);
        end
        @(negedge clk_in);
        in_valid = 1'b0;
        check("partial_idx", int'(load_idx), 10);
        #2 rst = 1'b1;
        #1;
        check("arst_i00", int'(o[0]), 0);
        check("arst_f22", int'(o[24]), 0);
        check("arst_idx", int'(load_idx), 0);
        check("arst_ready", int'(in_ready), 1);
        @(negedge clk_in);
        rst = 1'b0;

        // Job 3: bytes 100..124
        stream(100, 1'b0);
        check("j3_i00", int'(o[0]), 100);
        check("j3_i13", int'(o[7]), 107);
        check("j3_f22", int'(o[24]), 124);
        wait_done(runc);
        check("run_window_j3", runc, 64);
        pulse_ack();

        // One-cycle engine window on the second instance, ack offered in LOAD and RUN
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_in);
            in_valid1 = 1'b1; in_data1 = 8'(1 + i);
            ack1 = (i == 5);
        end
        @(negedge clk_in);
        in_valid1 = 1'b0;
        check("e1_busy", int'(busy1), 1);
        check("e1_eng_rst", int'(eng_rst1), 0);
        check("e1_ready", int'(in_ready1), 0);
        check("e1_done_early", int'(done1), 0);
        check("e1_f22", int'(o1[24]), 25);
        ack1 = 1'b1;
        @(negedge clk_in);
        ack1 = 1'b0;
        check("e1_done", int'(done1), 1);
        check("e1_busy_off", int'(busy1), 0);
        @(negedge clk_in);
        check("e1_done_hold", int'(done1), 1);
        ack1 = 1'b1;
        @(negedge clk_in);
        ack1 = 1'b0;
        check("e1_back_load", int'(in_ready1), 1);
        check("e1_i00_hold", int'(o1[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
